// File: rtl/hub75_pkg.sv
// Shared HUB75 panel constants: frame buffer geometry, port width helpers
// and the stream loader state encodings.
package hub75_pkg;

   localparam int unsigned FB_N_BANKS       = 2;
   localparam int unsigned FB_ROWS_PER_BANK = 32;
   localparam int unsigned FB_N_ROWS_DEF    = FB_N_BANKS * FB_ROWS_PER_BANK;
   localparam int unsigned FB_N_COLS_DEF    = 64;
   localparam int unsigned FB_BITDEPTH_DEF  = 8;

   // Address width for a frame buffer dimension; never narrower than one bit.
   function automatic int unsigned fb_addr_w(input int unsigned depth);
      int unsigned w;
      w = 1;
      if (depth > 1) w = $clog2(depth);
      return w;
   endfunction

   typedef logic [2:0] fsl_state_t;

   localparam fsl_state_t FSL_SYNC      = 3'd0;
   localparam fsl_state_t FSL_FILL      = 3'd1;
   localparam fsl_state_t FSL_COMMIT    = 3'd2;
   localparam fsl_state_t FSL_FLIP      = 3'd3;
   localparam fsl_state_t FSL_FLIP_WAIT = 3'd4;

endpackage

// File: rtl/fb_stream_loader.sv
// Pixel stream to line-buffer loader: fills one row at a time, commits each
// row to the frame buffer and requests a frame flip after the last row.
module fb_stream_loader
   import hub75_pkg::*;
#(
   parameter int unsigned N_ROWS   = FB_N_ROWS_DEF,
   parameter int unsigned N_COLS   = FB_N_COLS_DEF,
   parameter int unsigned BITDEPTH = FB_BITDEPTH_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [BITDEPTH-1:0]            s_data,
   input  logic                           s_sof,
   input  logic                           s_valid,
   output logic                           s_ready,
   output logic [fb_addr_w(N_ROWS)-1:0]   fbw_row_addr,
   output logic [fb_addr_w(N_COLS)-1:0]   fbw_col_addr,
   output logic [BITDEPTH-1:0]            fbw_data,
   output logic                           fbw_wren,
   output logic                           fbw_row_store,
   output logic                           fbw_row_swap,
   input  logic                           fbw_row_rdy,
   output logic                           frame_swap,
   input  logic                           frame_rdy,
   output logic                           sync_err,
   output logic                           frame_done
);

   localparam int unsigned ROW_W = fb_addr_w(N_ROWS);
   localparam int unsigned COL_W = fb_addr_w(N_COLS);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

   fsl_state_t          state_q, state_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic                s_ready_q, s_ready_d;
   logic                wren_q, wren_d;
   logic [BITDEPTH-1:0] data_q, data_d;
   logic [ROW_W-1:0]    row_addr_q, row_addr_d;
   logic [COL_W-1:0]    col_addr_q, col_addr_d;
   logic                row_store_q, row_store_d;
   logic                row_swap_q, row_swap_d;
   logic                frame_swap_q, frame_swap_d;
   logic                sync_err_q, sync_err_d;
   logic                frame_done_q, frame_done_d;

   logic                accept;
   logic                at_origin;
   logic                wr_en;
   logic [ROW_W-1:0]    wr_row;
   logic [COL_W-1:0]    wr_col;

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      wren_d       = 1'b0;
      data_d       = data_q;
      row_addr_d   = row_addr_q;
      col_addr_d   = col_addr_q;
      row_store_d  = 1'b0;
      row_swap_d   = 1'b0;
      frame_swap_d = 1'b0;
      sync_err_d   = 1'b0;
      frame_done_d = 1'b0;
      wr_en        = 1'b0;
      wr_row       = row_q;
      wr_col       = col_q;
      accept       = s_valid & s_ready_q;
      at_origin    = (row_q == '0) && (col_q == '0);

      case (state_q)
         FSL_SYNC: begin
            if (accept && s_sof) begin
               wr_en  = 1'b1;
               wr_row = '0;
               wr_col = '0;
            end
         end
         FSL_FILL: begin
            if (accept) begin
               if (s_sof && !at_origin) begin
                  // Early SOF: drop the partial row and restart the frame here.
                  sync_err_d = 1'b1;
                  wr_en      = 1'b1;
                  wr_row     = '0;
                  wr_col     = '0;
               end else if (!s_sof && at_origin) begin
                  sync_err_d = 1'b1;
                  state_d    = FSL_SYNC;
               end else begin
                  wr_en = 1'b1;
               end
            end
         end
         FSL_COMMIT: begin
            if (fbw_row_rdy) begin
               row_store_d = 1'b1;
               row_swap_d  = 1'b1;
               row_addr_d  = row_q;
               if (row_q == ROW_LAST) begin
                  state_d = FSL_FLIP;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = FSL_FILL;
               end
            end
         end
         FSL_FLIP: begin
            frame_swap_d = 1'b1;
            state_d      = FSL_FLIP_WAIT;
         end
         FSL_FLIP_WAIT: begin
            if (frame_rdy) begin
               frame_done_d = 1'b1;
               row_d        = '0;
               col_d        = '0;
               state_d      = FSL_FILL;
            end
         end
         default: begin
            state_d = FSL_SYNC;
            row_d   = '0;
            col_d   = '0;
         end
      endcase

      // Every accepted, kept word goes through the same write/advance path.
      if (wr_en) begin
         wren_d     = 1'b1;
         data_d     = s_data;
         row_addr_d = wr_row;
         col_addr_d = wr_col;
         row_d      = wr_row;
         if (wr_col == COL_LAST) begin
            col_d   = '0;
            state_d = FSL_COMMIT;
         end else begin
            col_d   = wr_col + 1'b1;
            state_d = FSL_FILL;
         end
      end

      s_ready_d = (state_d == FSL_SYNC) || (state_d == FSL_FILL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FSL_SYNC;
         row_q        <= '0;
         col_q        <= '0;
         s_ready_q    <= 1'b0;
         wren_q       <= 1'b0;
         data_q       <= '0;
         row_addr_q   <= '0;
         col_addr_q   <= '0;
         row_store_q  <= 1'b0;
         row_swap_q   <= 1'b0;
         frame_swap_q <= 1'b0;
         sync_err_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         s_ready_q    <= s_ready_d;
         wren_q       <= wren_d;
         data_q       <= data_d;
         row_addr_q   <= row_addr_d;
         col_addr_q   <= col_addr_d;
         row_store_q  <= row_store_d;
         row_swap_q   <= row_swap_d;
         frame_swap_q <= frame_swap_d;
         sync_err_q   <= sync_err_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign s_ready       = s_ready_q;
   assign fbw_row_addr  = row_addr_q;
   assign fbw_col_addr  = col_addr_q;
   assign fbw_data      = data_q;
   assign fbw_wren      = wren_q;
   assign fbw_row_store = row_store_q;
   assign fbw_row_swap  = row_swap_q;
   assign frame_swap    = frame_swap_q;
   assign sync_err      = sync_err_q;
   assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_fb_stream_loader.sv
// Directed bench for fb_stream_loader with a 4-row by 8-column frame.
module tb_fb_stream_loader;

   logic       clk;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_sof;
   logic       s_valid;
   logic       s_ready;
   logic [1:0] fbw_row_addr;
   logic [2:0] fbw_col_addr;
   logic [7:0] fbw_data;
   logic       fbw_wren;
   logic       fbw_row_store;
   logic       fbw_row_swap;
   logic       fbw_row_rdy;
   logic       frame_swap;
   logic       frame_rdy;
   logic       sync_err;
   logic       frame_done;

   int errors = 0;
   int checks = 0;

   fb_stream_loader #(.N_ROWS(4), .N_COLS(8), .BITDEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
      .fbw_row_addr(fbw_row_addr), .fbw_col_addr(fbw_col_addr),
      .fbw_data(fbw_data), .fbw_wren(fbw_wren),
      .fbw_row_store(fbw_row_store), .fbw_row_swap(fbw_row_swap),
      .fbw_row_rdy(fbw_row_rdy),
      .frame_swap(frame_swap), .frame_rdy(frame_rdy),
      .sync_err(sync_err), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event log, sampled 1 time unit after each rising edge.
   logic [7:0] log_data[$];
   logic [1:0] log_row[$];
   logic [2:0] log_col[$];
   logic [1:0] log_store_row[$];
   int n_swap, n_fswap, n_done, n_err, n_overlap;

   always @(posedge clk) begin
      #1;
      if (fbw_wren === 1'b1) begin
         log_data.push_back(fbw_data);
         log_row.push_back(fbw_row_addr);
         log_col.push_back(fbw_col_addr);
      end
      if (fbw_row_store === 1'b1) log_store_row.push_back(fbw_row_addr);
      if (fbw_row_swap === 1'b1) n_swap++;
      if (frame_swap === 1'b1) n_fswap++;
      if (frame_done === 1'b1) n_done++;
      if (sync_err === 1'b1) n_err++;
      if (fbw_wren === 1'b1 && (fbw_row_store | fbw_row_swap | frame_swap) === 1'b1) n_overlap++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      log_data.delete();
      log_row.delete();
      log_col.delete();
      log_store_row.delete();
      n_swap = 0; n_fswap = 0; n_done = 0; n_err = 0; n_overlap = 0;
   endtask

   // Entered and left just after a falling edge.
   task automatic send(input logic [7:0] d, input logic sof);
      int unsigned n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      while (s_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: s_ready=%b required 1 for word %h", s_ready, d);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; frame_rdy = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_log();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
      fbw_row_rdy = 1'b0; frame_rdy = 1'b0;
      clear_log();
      repeat (3) @(negedge clk);
      checks++;
      if ({s_ready, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap, sync_err, frame_done} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 0000000",
                  {s_ready, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap, sync_err, frame_done});
      end
      checks++;
      if ({fbw_row_addr, fbw_col_addr, fbw_data} !== 13'b0) begin
         errors++;
         $display("FAIL reset_addr_data: row=%h col=%h data=%h required 0 0 0",
                  fbw_row_addr, fbw_col_addr, fbw_data);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: s_ready=%b required 0", s_ready);
      end
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_first_edge: s_ready=%b required 1", s_ready);
      end
      clear_log();
   endtask

   task automatic test_full_frame(input string tag);
      int unsigned k;
      fbw_row_rdy = 1'b1;
      frame_rdy   = 1'b0;
      for (int i = 0; i < 32; i++) send(8'(i), (i == 0));
      k = 0;
      while (n_fswap == 0 && k < 50) begin @(negedge clk); k++; end
      frame_rdy = 1'b1;
      k = 0;
      while (n_done == 0 && k < 50) begin @(negedge clk); k++; end
      frame_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if (log_data.size() != 32) begin
         errors++;
         $display("FAIL %s_write_count: got %0d required 32", tag, log_data.size());
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (i >= log_data.size()) begin
            errors++;
            $display("FAIL %s_write_%0d: missing, required data=%h row=%0d col=%0d", tag, i, i, i / 8, i % 8);
         end else if (log_data[i] !== 8'(i) || log_row[i] !== 2'(i / 8) || log_col[i] !== 3'(i % 8)) begin
            errors++;
            $display("FAIL %s_write_%0d: data=%h row=%0d col=%0d required data=%h row=%0d col=%0d",
                     tag, i, log_data[i], log_row[i], log_col[i], i, i / 8, i % 8);
         end
      end
      checks++;
      if (log_store_row.size() != 4) begin
         errors++;
         $display("FAIL %s_store_count: got %0d required 4", tag, log_store_row.size());
      end else begin
         for (int r = 0; r < 4; r++) begin
            checks++;
            if (log_store_row[r] !== 2'(r)) begin
               errors++;
               $display("FAIL %s_store_row_%0d: got %0d required %0d", tag, r, log_store_row[r], r);
            end
         end
      end
      checks++;
      if (n_swap != 4 || n_fswap != 1 || n_done != 1) begin
         errors++;
         $display("FAIL %s_pulses: row_swap=%0d frame_swap=%0d frame_done=%0d required 4 1 1",
                  tag, n_swap, n_fswap, n_done);
      end
      checks++;
      if (n_err != 0 || n_overlap != 0) begin
         errors++;
         $display("FAIL %s_err_overlap: sync_err=%0d overlap=%0d required 0 0", tag, n_err, n_overlap);
      end
   endtask

   task automatic test_commit_stall();
      int bad;
      do_reset();
      fbw_row_rdy = 1'b0;
      for (int i = 0; i < 8; i++) send(8'(8'h40 + i), (i == 0));
      bad = 0;
      repeat (10) begin
         if (s_ready !== 1'b0 || fbw_row_store !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0 || log_store_row.size() != 0) begin
         errors++;
         $display("FAIL stall_hold: bad_cycles=%0d stores=%0d required 0 0", bad, log_store_row.size());
      end
      fbw_row_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (fbw_row_store !== 1'b1 || fbw_row_swap !== 1'b1 || fbw_row_addr !== 2'd0 || fbw_wren !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: store=%b swap=%b row=%0d wren=%b required 1 1 0 0",
                  fbw_row_store, fbw_row_swap, fbw_row_addr, fbw_wren);
      end
      @(negedge clk);
      checks++;
      if (fbw_row_store !== 1'b0 || log_store_row.size() != 1) begin
         errors++;
         $display("FAIL stall_single_pulse: store=%b stores=%0d required 0 1", fbw_row_store, log_store_row.size());
      end
   endtask

   task automatic test_presync_drop();
      do_reset();
      fbw_row_rdy = 1'b1;
      for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (log_data.size() != 0 || n_err != 0) begin
         errors++;
         $display("FAIL presync_drop: writes=%0d sync_err=%0d required 0 0", log_data.size(), n_err);
      end
      send(8'hAA, 1'b1);
      @(negedge clk);
      checks++;
      if (log_data.size() != 1) begin
         errors++;
         $display("FAIL presync_sof_count: writes=%0d required 1", log_data.size());
      end else if (log_data[0] !== 8'hAA || log_row[0] !== 2'd0 || log_col[0] !== 3'd0) begin
         checks++;
         errors++;
         $display("FAIL presync_sof_word: data=%h row=%0d col=%0d required aa 0 0",
                  log_data[0], log_row[0], log_col[0]);
      end
   endtask

   task automatic test_sof_mid_row();
      do_reset();
      fbw_row_rdy = 1'b1;
      for (int i = 0; i < 19; i++) send(8'(i), (i == 0));
      send(8'h55, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (n_err != 1) begin
         errors++;
         $display("FAIL midsof_err: sync_err pulses=%0d required 1", n_err);
      end
      checks++;
      if (log_store_row.size() != 2) begin
         errors++;
         $display("FAIL midsof_no_commit: stores=%0d required 2", log_store_row.size());
      end
      checks++;
      if (log_data.size() != 20) begin
         errors++;
         $display("FAIL midsof_write_count: writes=%0d required 20", log_data.size());
      end else if (log_data[19] !== 8'h55 || log_row[19] !== 2'd0 || log_col[19] !== 3'd0) begin
         errors++;
         $display("FAIL midsof_word: data=%h row=%0d col=%0d required 55 0 0",
                  log_data[19], log_row[19], log_col[19]);
      end
      for (int i = 0; i < 7; i++) send(8'(8'h60 + i), 1'b0);
      repeat (4) @(negedge clk);
      checks++;
      if (log_store_row.size() != 3 || n_err != 1) begin
         errors++;
         $display("FAIL midsof_restart: stores=%0d sync_err=%0d required 3 1", log_store_row.size(), n_err);
      end else if (log_store_row[2] !== 2'd0 || log_col[26] !== 3'd7 || log_row[26] !== 2'd0) begin
         errors++;
         $display("FAIL midsof_restart_row: store_row=%0d last_row=%0d last_col=%0d required 0 0 7",
                  log_store_row[2], log_row[26], log_col[26]);
      end
   endtask

   task automatic test_reset_mid_row();
      do_reset();
      fbw_row_rdy = 1'b1;
      for (int i = 0; i < 13; i++) send(8'(8'hC0 + i), (i == 0));
      rst_n = 1'b0;
      #1;
      checks++;
      if (s_ready !== 1'b0 || fbw_wren !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: s_ready=%b wren=%b required 0 0", s_ready, fbw_wren);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (log_store_row.size() != 1 || n_fswap != 0) begin
         errors++;
         $display("FAIL reset_no_commit: stores=%0d frame_swaps=%0d required 1 0", log_store_row.size(), n_fswap);
      end
      clear_log();
      test_full_frame("after_reset");
   endtask

   task automatic test_flip_wait();
      int unsigned k;
      int bad;
      do_reset();
      fbw_row_rdy = 1'b1;
      frame_rdy   = 1'b0;
      for (int i = 0; i < 32; i++) send(8'(i), (i == 0));
      k = 0;
      while (n_fswap == 0 && k < 50) begin @(negedge clk); k++; end
      checks++;
      if (n_fswap != 1) begin
         errors++;
         $display("FAIL flip_swap_seen: frame_swaps=%0d required 1", n_fswap);
      end
      bad = 0;
      repeat (20) begin
         if (s_ready !== 1'b0 || frame_done !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0 || n_done != 0) begin
         errors++;
         $display("FAIL flip_hold: bad_cycles=%0d done=%0d required 0 0", bad, n_done);
      end
      frame_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL flip_done_pulse: frame_done=%b required 1", frame_done);
      end
      frame_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || n_done != 1 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL flip_done_once: frame_done=%b count=%0d s_ready=%b required 0 1 1",
                  frame_done, n_done, s_ready);
      end
   endtask

   task automatic test_resync();
      clear_log();
      send(8'h11, 1'b0);
      @(negedge clk);
      checks++;
      if (n_err != 1 || log_data.size() != 0) begin
         errors++;
         $display("FAIL resync_origin_nosof: sync_err=%0d writes=%0d required 1 0", n_err, log_data.size());
      end
      send(8'h22, 1'b0);
      send(8'h33, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (n_err != 1 || log_data.size() != 1) begin
         errors++;
         $display("FAIL resync_sync_state: sync_err=%0d writes=%0d required 1 1", n_err, log_data.size());
      end else if (log_data[0] !== 8'h33 || log_row[0] !== 2'd0 || log_col[0] !== 3'd0) begin
         errors++;
         $display("FAIL resync_word: data=%h row=%0d col=%0d required 33 0 0",
                  log_data[0], log_row[0], log_col[0]);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame("frame");
      test_commit_stall();
      test_presync_drop();
      test_sof_mid_row();
      test_reset_mid_row();
      test_flip_wait();
      test_resync();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
